answer_judge: RTL and testbench
===============================

# answer_judge

Player-side responder for the arithmetic quiz game. The question generator issues an operator challenge, and this block answers it. It debounces the five player switches, captures the player's operator choice for the current question, and judges it against the issued operator. It keeps a two-digit BCD score and drives two 7-segment digits showing that score.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required before a switch bit changes its debounced value.
- HOLD_CYCLES, 8: cycles spent in HOLD after a verdict before a new question is accepted.
- TIMEOUT_CYCLES, 1000: cycles allowed in ARMED before a forced wrong verdict. Used only with JUDGE_TIMEOUT_EN.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- q_valid  in  1  question offered. Held high until accepted.
- q_op  in  2  operator of the offered question: 0 +, 1 -, 2 *, 3 /.
- q_ready  out  1  block can accept a question.
- switch  in  5  raw asynchronous switches. [3:0] select the operator (one-hot); [4] skips the question.
- result_valid  out  1  one-cycle verdict pulse.
- result_correct  out  1  verdict. Valid while result_valid is high and held until the next verdict.
- result_skipped  out  1  verdict came from skip or timeout. Same validity as result_correct.
- score_ones  out  4  BCD ones digit.
- score_tens  out  4  BCD tens digit.
- led_ones  out  7  segments abcdefg (a = MSB), active-high, for score_ones.
- led_tens  out  7  segments abcdefg for score_tens.

## Operation
- Input conditioning, per switch bit:
  - 2-FF synchronizer.
  - A stability counter updates the debounced bit after DEBOUNCE_CYCLES equal samples.
  - A press event is a 0->1 transition of the debounced bit.
- States: IDLE, WAIT_RELEASE, ARMED, JUDGE, HOLD.
- IDLE:
  - q_ready=1.
  - On q_valid && q_ready: latch q_op, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Stays until debounced switch == 5'b0, then goes to ARMED.
  - Presses still held over from the previous round are never judged.
- ARMED, on any press event:
  - Latch the debounced vector, go to JUDGE.
  - Multiple press events in the same cycle are latched together.
- JUDGE (one cycle):
  - If bit 4 is set: skipped=1, correct=0.
  - Otherwise correct=1 only when the latched vector equals exactly one-hot (1 << op). Any other pattern is wrong.
  - Assert result_valid, update the score, go to HOLD.
- HOLD: count HOLD_CYCLES cycles, then go to IDLE.
- Score:
  - A correct verdict adds 1 in BCD.
  - Ones 9 -> 0 with a carry into tens.
  - Saturates at 99.
  - Wrong and skipped verdicts leave the score unchanged.
- Segment map, per digit:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011.
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011.
  - Values 10-15 never occur; decode them to 0000001.
  - Segment outputs are registered.

## Timing
- Reset values:
  - State IDLE, q_ready=1.
  - result_valid=0, result_correct=0, result_skipped=0.
  - Score 00; led_ones = led_tens = 1111110.
  - Synchronizers, debounced bits and counters all cleared.
- reset low overrides everything, including mid-round. The latched op and pending verdict are discarded, with no result_valid pulse.
- Question handshake: transfer occurs on a clk edge with q_valid=1 and q_ready=1. q_ready drops the next cycle.
- Latency:
  - Raw switch edge to debounced edge: 2 + DEBOUNCE_CYCLES cycles.
  - Press event to result_valid: 2 cycles (ARMED->JUDGE, pulse registered out of JUDGE).
  - score_* updates in the same cycle result_valid rises; led_* updates one cycle later.
- q_ready returns to 1 exactly HOLD_CYCLES cycles after the result_valid cycle.
- Switch bounce shorter than DEBOUNCE_CYCLES produces no event.
- q_valid while q_ready=0 is ignored; the source holds it.

## Configuration
- JUDGE_TIMEOUT_EN defined:
  - A cycle counter runs in ARMED.
  - After TIMEOUT_CYCLES cycles with no press event, go to JUDGE with correct=0, skipped=1.
  - A press event in the same cycle the timeout expires takes priority.
- Not defined:
  - No counter is built, and ARMED waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Correct answer: question q_op=2 accepted; switch[2] held for 40 cycles -> result_valid, correct=1, skipped=0; score 00 -> 01; led_ones = 0110000.
- Bounce and wrong answer: q_op=0; switch[0] toggled every 5 cycles for 30 cycles (DEBOUNCE_CYCLES=16), then switch[1] held -> single verdict, correct=0, score unchanged.
- Carry and saturation:
  - From score 09, correct answer -> tens=1, ones=0, led_tens = 0110000.
  - From score 99, correct answer -> stays 99.
- Release gating and skip:
  - switch[3] held across question acceptance -> no verdict until released and re-pressed.
  - switch[4] press -> correct=0, skipped=1.
- Multi-press, timeout and reset:
  - switch[1] and switch[3] pressed together with q_op=1 -> wrong.
  - With JUDGE_TIMEOUT_EN and TIMEOUT_CYCLES=50, no press -> verdict skipped=1 after 50 ARMED cycles.
  - reset low during ARMED -> no pulse, score 00, q_ready=1.

Source files
------------

// File: rtl/answer_judge.sv
// Quiz responder: debounces player switches, judges the chosen operator, keeps a BCD score.
// Optional build macro JUDGE_TIMEOUT_EN forces a skipped verdict after TIMEOUT_CYCLES in ARMED.
module answer_judge #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       q_valid,
  input  logic [1:0] q_op,
  output logic       q_ready,
  input  logic [4:0] switch,
  output logic       result_valid,
  output logic       result_correct,
  output logic       result_skipped,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [6:0] led_ones,
  output logic [6:0] led_tens
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_RELEASE, ARMED, JUDGE, HOLD
  } state_t;

  state_t state, state_nx;

  logic [4:0]    sync1, sync2, deb, deb_q;
  logic [DW-1:0] db_cnt [5];
  logic [4:0]    press;
  logic [1:0]    op_q;
  logic [4:0]    vec_q;
  logic [HW-1:0] hold_cnt;
  logic          tmo_hit;
  logic          hit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000001;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

`ifdef JUDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (!reset) tmo_cnt <= '0;
    else if (state == ARMED) tmo_cnt <= tmo_cnt + 1'b1;
    else tmo_cnt <= '0;
  end

  assign tmo_hit = (state == ARMED) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (q_valid) state_nx = WAIT_RELEASE;
      WAIT_RELEASE: if (deb == 5'b0) state_nx = ARMED;
      ARMED:        if ((|press) || tmo_hit) state_nx = JUDGE;
      JUDGE:        state_nx = HOLD;
      HOLD:
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_comb begin
    q_ready = (state == IDLE);
  end

  // A real press wins over a timeout expiring in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= '0;
      vec_q    <= '0;
      hold_cnt <= '0;
    end else begin
      if (state == IDLE && q_valid) op_q <= q_op;
      if (state == ARMED) begin
        if (|press) vec_q <= deb;
        else if (tmo_hit) vec_q <= 5'b10000;
      end
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else hold_cnt <= '0;
    end
  end

  assign hit = !vec_q[4] && (vec_q[3:0] == (4'b0001 << op_q));

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      result_skipped <= 1'b0;
      score_ones     <= '0;
      score_tens     <= '0;
    end else if (state == JUDGE) begin
      result_valid   <= 1'b1;
      result_correct <= hit;
      result_skipped <= vec_q[4];
      if (hit && !(score_tens == 4'd9 && score_ones == 4'd9)) begin
        if (score_ones == 4'd9) begin
          score_ones <= '0;
          score_tens <= score_tens + 1'b1;
        end else begin
          score_ones <= score_ones + 1'b1;
        end
      end
    end else begin
      result_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_ones <= 7'b1111110;
      led_tens <= 7'b1111110;
    end else begin
      led_ones <= seg7(score_ones);
      led_tens <= seg7(score_tens);
    end
  end

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: rounds, bounce, carry/saturation, gating, timeout, reset.
module tb_answer_judge;

  logic       clk = 1'b0;
  logic       reset;
  logic       q_valid;
  logic [1:0] q_op;
  logic       q_ready;
  logic [4:0] switch;
  logic       result_valid;
  logic       result_correct;
  logic       result_skipped;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [6:0] led_ones;
  logic [6:0] led_tens;

  int errors = 0;
  int checks = 0;

  int   cyc = 0;
  int   pulses = 0;
  int   p_cyc, r_cyc;
  logic p_corr, p_skp, rdy_q = 1'b0;
  logic [3:0] p_ones, p_tens;
  logic [6:0] p_led_ones;

  answer_judge #(
    .DEBOUNCE_CYCLES(16),
    .HOLD_CYCLES(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .q_valid(q_valid),
    .q_op(q_op),
    .q_ready(q_ready),
    .switch(switch),
    .result_valid(result_valid),
    .result_correct(result_correct),
    .result_skipped(result_skipped),
    .score_ones(score_ones),
    .score_tens(score_tens),
    .led_ones(led_ones),
    .led_tens(led_tens)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (result_valid) begin
      pulses++;
      p_cyc = cyc;
      p_corr = result_correct;
      p_skp = result_skipped;
      p_ones = score_ones;
      p_tens = score_tens;
      p_led_ones = led_ones;
    end
    if (q_ready && !rdy_q) r_cyc = cyc;
    rdy_q = q_ready;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] op);
    for (int i = 0; i < 50 && !q_ready; i++) @(negedge clk);
    q_valid = 1'b1;
    q_op = op;
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int p0, input int n, output logic got);
    for (int i = 0; i < n && pulses == p0; i++) @(negedge clk);
    got = (pulses > p0);
  endtask

  int   c0, p0, lat;
  logic got;

  task automatic round(input logic [1:0] op, input logic [4:0] sw);
    offer(op);
    p0 = pulses;
    c0 = cyc;
    switch = sw;
    wait_pulse(p0, 60, got);
    chk("round_pulse", got, 1);
    lat = p_cyc - c0;
    switch = 5'b0;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    q_valid = 1'b0;
    q_op = 2'd0;
    switch = 5'b0;
    repeat (3) @(negedge clk);
    chk("rst_q_ready", q_ready, 1);
    chk("rst_valid", result_valid, 0);
    chk("rst_correct", result_correct, 0);
    chk("rst_skipped", result_skipped, 0);
    chk("rst_score", {score_tens, score_ones}, 8'h00);
    chk("rst_led_ones", led_ones, 7'b1111110);
    chk("rst_led_tens", led_tens, 7'b1111110);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    round(2'd2, 5'b00100);
    chk("r1_correct", p_corr, 1);
    chk("r1_skipped", p_skp, 0);
    chk("r1_score_at_pulse", {p_tens, p_ones}, 8'h01);
    chk("r1_led_at_pulse", p_led_ones, 7'b1111110);
    chk("r1_led_after", led_ones, 7'b0110000);
    chk("r1_latency", lat, 20);
    chk("r1_hold", r_cyc - p_cyc, 8);

    offer(2'd0);
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      switch = (i % 2 == 0) ? 5'b00001 : 5'b00000;
      repeat (5) @(negedge clk);
    end
    chk("bounce_no_pulse", pulses - p0, 0);
    switch = 5'b00010;
    repeat (60) @(negedge clk);
    chk("bounce_pulses", pulses - p0, 1);
    chk("bounce_correct", p_corr, 0);
    chk("bounce_skipped", p_skp, 0);
    chk("bounce_score", {score_tens, score_ones}, 8'h01);
    switch = 5'b0;
    repeat (25) @(negedge clk);

    for (int i = 0; i < 8; i++) round(2'd3, 5'b01000);
    chk("score_09", {score_tens, score_ones}, 8'h09);
    chk("led_9", led_ones, 7'b1111011);
    round(2'd1, 5'b00010);
    chk("carry_score", {score_tens, score_ones}, 8'h10);
    chk("carry_led_tens", led_tens, 7'b0110000);
    chk("carry_led_ones", led_ones, 7'b1111110);

    round(2'd0, 5'b10000);
    chk("skip_correct", p_corr, 0);
    chk("skip_skipped", p_skp, 1);
    chk("skip_score", {score_tens, score_ones}, 8'h10);

    switch = 5'b01000;
    repeat (25) @(negedge clk);
    offer(2'd3);
    p0 = pulses;
    repeat (40) @(negedge clk);
    chk("gate_held", pulses - p0, 0);
    switch = 5'b0;
    repeat (25) @(negedge clk);
    chk("gate_released", pulses - p0, 0);
    switch = 5'b01000;
    wait_pulse(p0, 60, got);
    chk("gate_repress", got, 1);
    chk("gate_correct", p_corr, 1);
    switch = 5'b0;
    repeat (25) @(negedge clk);
    chk("gate_score", {score_tens, score_ones}, 8'h11);

    round(2'd1, 5'b01010);
    chk("multi_correct", p_corr, 0);
    chk("multi_skipped", p_skp, 0);
    chk("multi_score", {score_tens, score_ones}, 8'h11);

    offer(2'd0);
    p0 = pulses;
    c0 = cyc;
    wait_pulse(p0, 60, got);
`ifdef JUDGE_TIMEOUT_EN
    chk("tmo_pulse", got, 1);
    chk("tmo_skipped", p_skp, 1);
    chk("tmo_correct", p_corr, 0);
    chk("tmo_latency", p_cyc - c0, 52);
    chk("tmo_score", {score_tens, score_ones}, 8'h11);
    repeat (20) @(negedge clk);
    offer(2'd0);
`else
    chk("no_tmo_pulse", got, 0);
    chk("no_tmo_ready", q_ready, 0);
`endif

    switch = 5'b00001;
    repeat (10) @(negedge clk);
    p0 = pulses;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_ready", q_ready, 1);
    chk("mid_rst_score", {score_tens, score_ones}, 8'h00);
    chk("mid_rst_led", led_ones, 7'b1111110);
    switch = 5'b0;
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_pulse", pulses - p0, 0);

    for (int i = 0; i < 99; i++) round(2'd0, 5'b00001);
    chk("score_99", {score_tens, score_ones}, 8'h99);
    chk("led_99_tens", led_tens, 7'b1111011);
    round(2'd2, 5'b00100);
    chk("sat_correct", p_corr, 1);
    chk("sat_score", {score_tens, score_ones}, 8'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
